mac_ctrl_fsm: RTL and testbench

MAC_CTRL_FSM -- requirements
Module: mac_ctrl_fsm

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_len_counter.sv | 57 +++++
 rtl/mac_ctrl_fsm.sv | 186 ++++++++++++++++++
 tb/tb_mac_ctrl_fsm.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared definitions for the MAC control block: state
//               encoding of the control FSM and the default operand-pair
//               length width.
// Contents    : LEN_W_DEFAULT  - default width of length / pair counter
//               mac_state_e    - binary state encoding
//                                (IDLE=0, CLEAR=1, RUN=2, DRAIN=3, DONE=4)
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int unsigned LEN_W_DEFAULT = 8;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mac_state_e;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_len_counter.sv
`default_nettype none
// ============================================================================
// Module      : mac_len_counter
// Description : Counts operand pairs accepted in the current dot product and
//               flags the terminal count (the pair now being counted is the
//               last one of the requested length).
// Ports       : clk_i   in   clock, rising edge
//               rst_ni  in   asynchronous active-low reset
//               clr_i   in   synchronous clear (new operation accepted)
//               inc_i   in   count one accepted pair
//               len_i   in   latched operation length
//               cnt_o   out  pairs accepted so far
//               last_o  out  cnt_o == len_i - 1 (next pair completes length)
// Revision    : 1.0 - initial release
// ============================================================================
module mac_len_counter #(
  parameter int LEN_W = mac_pkg::LEN_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] cnt_o,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W:0]   w_cnt_plus1;

  // One extra bit so that the all-ones length compares without wrapping.
  assign w_cnt_plus1 = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
  assign last_o      = (w_cnt_plus1 == {1'b0, len_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != len_i)) begin
      // Saturate at the latched length: the count can never pass it.
      cnt_d = w_cnt_plus1[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : mac_len_counter
`default_nettype wire

// File: rtl/mac_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mac_ctrl_fsm
// Description : Control FSM for a multiply-accumulate dot-product datapath.
//               Sequences IDLE -> CLEAR -> RUN (-> DRAIN) -> DONE, issues the
//               accumulator clear, per-pair multiplier/accumulator enables and
//               the result-valid handshake.
// Config      : MAC_CTRL_PIPE_EN - when defined, ACC_EN lags MUL_EN by one
//               register stage and a one-cycle DRAIN state issues the last
//               accumulate before DONE. When undefined, ACC_EN follows MUL_EN
//               in the same cycle and DRAIN does not exist in hardware.
// Parameters  : LEN_W      - width of LEN and CNT
//               CNT_OUT_EN - 1: CNT shows the pair counter, 0: CNT tied to 0
// Ports       : clk_i        in   clock, rising edge
//               rst_ni       in   asynchronous active-low reset
//               start_i      in   start request, sampled in IDLE only
//               len_i        in   number of operand pairs
//               abort_i      in   cancel current operation
//               in_valid_i   in   operand pair present
//               in_ready_o   out  FSM accepts operand pair
//               acc_clr_o    out  clear accumulator
//               mul_en_o     out  multiplier enable (= handshake)
//               acc_en_o     out  accumulator enable
//               out_valid_o  out  result available
//               out_ready_i  in   consumer takes result
//               busy_o       out  state is not IDLE
//               cnt_o        out  pairs accepted in current operation
// Revision    : 1.0 - initial release
// ============================================================================
module mac_ctrl_fsm
  import mac_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEFAULT,
  parameter bit CNT_OUT_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             acc_clr_o,
  output logic             mul_en_o,
  output logic             acc_en_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic [LEN_W-1:0] cnt_o
);

  mac_state_e       state_q;
  mac_state_e       state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;

  // Outputs registered from the next state so they never depend on inputs.
  logic             in_ready_q;
  logic             acc_clr_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             w_handshake;
  logic             w_abort;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_last;
  logic [LEN_W-1:0] w_cnt;

`ifdef MAC_CTRL_PIPE_EN
  logic             pipe_q;
`endif

  assign w_handshake = in_valid_i & in_ready_q;
  // busy_q mirrors "state is not IDLE", so abort is ignored while idle.
  assign w_abort     = abort_i & busy_q;
  assign w_cnt_clr   = (state_q == ST_IDLE) & start_i;
  assign w_cnt_inc   = w_handshake & ~abort_i;

  mac_len_counter #(
    .LEN_W (LEN_W)
  ) u_len_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_cnt_clr),
    .inc_i  (w_cnt_inc),
    .len_i  (len_q),
    .cnt_o  (w_cnt),
    .last_o (w_last)
  );

  // --------------------------------------------------------------------------
  // Next-state logic; abort dominates every other transition.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (w_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_CLEAR;
            len_d   = len_i;
          end
        end
        ST_CLEAR: begin
          state_d = (len_q == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (w_handshake && w_last) begin
`ifdef MAC_CTRL_PIPE_EN
            state_d = ST_DRAIN;
`else
            state_d = ST_DONE;
`endif
          end
        end
`ifdef MAC_CTRL_PIPE_EN
        ST_DRAIN: begin
          state_d = ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State, latched length and registered output decode.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MAC_CTRL_PIPE_EN
      pipe_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      in_ready_q  <= (state_d == ST_RUN);
      acc_clr_q   <= (state_d == ST_CLEAR);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
`ifdef MAC_CTRL_PIPE_EN
      // A pair accepted in the abort cycle must not be accumulated later.
      pipe_q      <= w_handshake & ~abort_i;
`endif
    end
  end

  assign in_ready_o  = in_ready_q;
  assign acc_clr_o   = acc_clr_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign mul_en_o    = w_handshake;

`ifdef MAC_CTRL_PIPE_EN
  assign acc_en_o    = pipe_q & ~abort_i;
`else
  assign acc_en_o    = w_handshake & ~abort_i;
`endif

  generate
    if (CNT_OUT_EN) begin : g_cnt_out
      assign cnt_o = w_cnt;
    end else begin : g_cnt_zero
      assign cnt_o = '0;
    end
  endgenerate

endmodule : mac_ctrl_fsm
`default_nettype wire

// File: tb/tb_mac_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_ctrl_fsm
// Description : Self-checking bench for mac_ctrl_fsm. A behavioural reference
//               model pushes the expected per-cycle outputs into a queue as
//               stimulus is applied; each scenario pops and compares them,
//               plus scenario-specific latency / pulse-count checks.
// Config      : honours MAC_CTRL_PIPE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_ctrl_fsm;

  localparam int LEN_W = 8;

`ifdef MAC_CTRL_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  localparam int S_IDLE  = 0;
  localparam int S_CLEAR = 1;
  localparam int S_RUN   = 2;
  localparam int S_DRAIN = 3;
  localparam int S_DONE  = 4;

  // {acc_clr, in_ready, mul_en, acc_en, out_valid, busy, cnt}
  typedef logic [LEN_W+5:0] obs_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic             acc_clr;
  logic             mul_en;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [LEN_W-1:0] cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  int   m_state;
  int   m_len;
  int   m_cnt;
  logic m_pipe;

  always #5 clk = ~clk;

  mac_ctrl_fsm #(
    .LEN_W      (LEN_W),
    .CNT_OUT_EN (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .len_i       (len),
    .abort_i     (abort),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .acc_clr_o   (acc_clr),
    .mul_en_o    (mul_en),
    .acc_en_o    (acc_en),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .cnt_o       (cnt)
  );

  // ---------------------------------------------------------------- model
  task automatic model_reset();
    m_state = S_IDLE;
    m_len   = 0;
    m_cnt   = 0;
    m_pipe  = 1'b0;
  endtask

  function automatic obs_t model_out();
    logic e_rdy;
    logic e_mul;
    logic e_acc;
    e_rdy = (m_state == S_RUN);
    e_mul = e_rdy & in_valid;
    if (PIPE != 0) e_acc = m_pipe & ~abort;
    else           e_acc = e_mul & ~abort;
    return {(m_state == S_CLEAR), e_rdy, e_mul, e_acc, (m_state == S_DONE),
            (m_state != S_IDLE), LEN_W'(m_cnt)};
  endfunction

  task automatic model_advance();
    logic hs;
    hs = (m_state == S_RUN) && in_valid;
    if ((m_state != S_IDLE) && abort) begin
      m_state = S_IDLE;
      m_pipe  = 1'b0;
    end else begin
      m_pipe = hs;
      case (m_state)
        S_IDLE:  if (start) begin m_state = S_CLEAR; m_len = int'(len); m_cnt = 0; end
        S_CLEAR: m_state = (m_len == 0) ? S_DONE : S_RUN;
        S_RUN: begin
          if (hs) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == m_len) m_state = (PIPE != 0) ? S_DRAIN : S_DONE;
          end
        end
        S_DRAIN: m_state = S_DONE;
        S_DONE:  if (out_ready) m_state = S_IDLE;
        default: m_state = S_IDLE;
      endcase
    end
  endtask

  function automatic obs_t dut_obs();
    return {acc_clr, in_ready, mul_en, acc_en, out_valid, busy, cnt};
  endfunction

  // Apply one cycle of stimulus at the falling edge, record the expected
  // outputs for this cycle, then step the model past the next rising edge.
  task automatic drive_cycle(input logic st, input logic [LEN_W-1:0] ln,
                             input logic ab, input logic iv, input logic ordy);
    @(negedge clk);
    start     = st;
    len       = ln;
    abort     = ab;
    in_valid  = iv;
    out_ready = ordy;
    #2;
    exp_q.push_back(model_out());
    model_advance();
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    obs_t o;
    obs_t e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_checks++;
    if (dut_obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero", dut_obs());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // START on the very first rising edge after release must be taken.
    for (int c = 0; c < 7; c++) begin
      drive_cycle(c == 0, LEN_W'(1), 1'b0, 1'b1, 1'b1);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: got %b expected %b", c, o, e);
      end
      if (c == 1) begin
        n_checks++;
        if (acc_clr !== 1'b1) begin
          n_fail++;
          $display("FAIL first_start_after_reset: acc_clr got %b expected 1", acc_clr);
        end
      end
    end
  endtask

  task automatic test_basic();
    obs_t o;
    obs_t e;
    int   first_ov  = -1;
    int   first_acc = -1;
    int   n_mul     = 0;
    for (int c = 0; c < 11; c++) begin
      drive_cycle(c == 0, LEN_W'(4), 1'b0, 1'b1, c >= 8);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_len4 cyc %0d: got %b expected %b", c, o, e);
      end
      if (mul_en === 1'b1) n_mul++;
      if (acc_en === 1'b1 && first_acc < 0) first_acc = c;
      if (out_valid === 1'b1 && first_ov < 0) first_ov = c;
    end
    n_checks++;
    if (first_ov != 6 + PIPE) begin
      n_fail++;
      $display("FAIL basic_latency: out_valid at cycle %0d expected %0d", first_ov, 6 + PIPE);
    end
    n_checks++;
    if (first_acc != 2 + PIPE) begin
      n_fail++;
      $display("FAIL basic_first_acc_en: cycle %0d expected %0d", first_acc, 2 + PIPE);
    end
    n_checks++;
    if (n_mul != 4) begin
      n_fail++;
      $display("FAIL basic_mul_pulses: got %0d expected 4", n_mul);
    end
  endtask

  task automatic test_toggle();
    obs_t o;
    obs_t e;
    int   n_mul = 0;
    int   exp_cnt[5] = '{1, 1, 2, 2, 3};
    logic iv;
    for (int c = 0; c < 10; c++) begin
      iv = (c >= 2 && c <= 6) ? (((c - 2) % 2) == 0) : 1'b0;
      drive_cycle(c == 0, LEN_W'(3), 1'b0, iv, c >= 7);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL toggle_len3 cyc %0d: got %b expected %b", c, o, e);
      end
      if (mul_en === 1'b1) n_mul++;
      if (c >= 3 && c <= 7) begin
        n_checks++;
        if (int'(cnt) != exp_cnt[c-3]) begin
          n_fail++;
          $display("FAIL toggle_cnt cyc %0d: got %0d expected %0d", c, cnt, exp_cnt[c-3]);
        end
      end
    end
    n_checks++;
    if (n_mul != 3) begin
      n_fail++;
      $display("FAIL toggle_mul_pulses: got %0d expected 3", n_mul);
    end
  endtask

  task automatic test_len_zero();
    obs_t o;
    obs_t e;
    int   n_mul  = 0;
    int   n_wait = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(c == 0, LEN_W'(0), 1'b0, 1'b1, c >= 7);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL len_zero cyc %0d: got %b expected %b", c, o, e);
      end
      if (mul_en === 1'b1) n_mul++;
      if (out_valid === 1'b1 && out_ready === 1'b0) n_wait++;
    end
    n_checks++;
    if (n_mul != 0 || n_wait != 5) begin
      n_fail++;
      $display("FAIL len_zero_counts: mul %0d hold %0d expected mul 0 hold 5", n_mul, n_wait);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    obs_t e;
    int   n_ov = 0;
    for (int c = 0; c < 16; c++) begin
      drive_cycle((c == 0) || (c == 3) || (c == 8), (c < 8) ? LEN_W'(8) : LEN_W'(1),
                  (c == 4) || (c == 13), 1'b1, 1'b0);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort cyc %0d: got %b expected %b", c, o, e);
      end
      if (c < 8 && out_valid === 1'b1) n_ov++;
      if (c == 4) begin
        n_checks++;
        if (acc_en !== 1'b0 || cnt !== LEN_W'(2)) begin
          n_fail++;
          $display("FAIL abort_cycle: acc_en %b cnt %0d expected 0 and 2", acc_en, cnt);
        end
      end
      if (c == 5 || c == 14) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_to_idle cyc %0d: busy %b expected 0", c, busy);
        end
      end
    end
    n_checks++;
    if (n_ov != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid cycles %0d expected 0", n_ov);
    end
  endtask

  task automatic test_reset_midrun();
    obs_t o;
    obs_t e;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(c == 0, LEN_W'(8), 1'b0, 1'b1, 1'b0);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midrun_pre cyc %0d: got %b expected %b", c, o, e);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (dut_obs() !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected all zero", dut_obs());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(c == 0, LEN_W'(2), 1'b0, 1'b1, 1'b1);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midrun_post cyc %0d: got %b expected %b", c, o, e);
      end
    end
  endtask

  task automatic test_max_len();
    obs_t o;
    obs_t e;
    int   first_ov = -1;
    int   n_mul    = 0;
    logic [LEN_W-1:0] cnt_at_ov = '0;
    for (int c = 0; c < 265; c++) begin
      drive_cycle(c == 0, LEN_W'(255), 1'b0, 1'b1, c >= 262);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL max_len cyc %0d: got %b expected %b", c, o, e);
      end
      if (mul_en === 1'b1) n_mul++;
      if (out_valid === 1'b1 && first_ov < 0) begin
        first_ov  = c;
        cnt_at_ov = cnt;
      end
    end
    n_checks++;
    if (first_ov != 257 + PIPE || cnt_at_ov !== LEN_W'(255) || n_mul != 255) begin
      n_fail++;
      $display("FAIL max_len_summary: ov %0d cnt %0d mul %0d expected %0d 255 255",
               first_ov, cnt_at_ov, n_mul, 257 + PIPE);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    obs_t e;
    int   n_clr = 0;
    int   n_ov  = 0;
    for (int c = 0; c < 28; c++) begin
      drive_cycle(c < 20, LEN_W'(2), 1'b0, 1'b1, 1'b1);
      o = dut_obs();
      e = exp_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %b expected %b", c, o, e);
      end
      if (acc_clr === 1'b1) n_clr++;
      if (out_valid === 1'b1) n_ov++;
    end
    n_checks++;
    if (n_clr != 4 || n_ov != 4) begin
      n_fail++;
      $display("FAIL back_to_back_ops: clears %0d results %0d expected 4 and 4", n_clr, n_ov);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_toggle();
    test_len_zero();
    test_abort();
    test_reset_midrun();
    test_max_len();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_mac_ctrl_fsm
`default_nettype wire
